// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline stage registers:
// skid-register state encoding, NOP bubble encoding and IF payload widths.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam int IF_PC_W      = 32;
  localparam int IF_INSTR_W   = 32;
  localparam int IF_PAYLOAD_W = IF_PC_W + IF_INSTR_W;

  // sll $0,$0,0 is the canonical MIPS NOP, used as the flushed bubble
  localparam logic [IF_PAYLOAD_W-1:0] NOP_PAYLOAD = '0;

endpackage

// File: rtl/pipe_skid_entry.sv
// Single payload register with synchronous clear (priority) and load enable;
// used as the overflow entry of pipe_skid_reg.
module pipe_skid_entry #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clear)     q_d = CLR_VAL;
    else if (load) q_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= CLR_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with one skid entry, flush and freeze.
// Define PIPE_STALL_CNT_EN to add the saturating freeze-cycle counter port stall_cnt.
module pipe_skid_reg
  import mips_pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter int                NUM_FREEZE = 2,
  parameter logic [DATA_W-1:0] FLUSH_VAL  = DATA_W'(NOP_PAYLOAD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  flush,
  input  logic [NUM_FREEZE-1:0] freeze
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  pipe_state_e       state_d, state_q;
  logic [DATA_W-1:0] main_d, main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_d, in_ready_q;
  logic              skid_load, skid_clear;
  logic              freeze_any, in_fire, out_fire;

  // Handshakes are gated here so a frozen or flushing stage never transfers
  assign freeze_any = |freeze;
  assign in_ready   = in_ready_q & ~freeze_any & ~flush;
  assign out_valid  = (state_q != EMPTY) & ~freeze_any;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign out_data   = main_q;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_d     = FLUSH_VAL;
      skid_clear = 1'b1;
    end else if (!freeze_any) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = FULL;
            main_d  = in_data;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d   = SKID;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Registered ready: low only while both entries are occupied
    in_ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= FLUSH_VAL;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_skid_entry #(
    .DATA_W  (DATA_W),
    .CLR_VAL (FLUSH_VAL)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_data),
    .q     (skid_q)
  );

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;

  // Counts frozen cycles only; flush deliberately leaves it alone
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze_any && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 16'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: streaming, backpressure, freeze, flush,
// asynchronous reset and (with PIPE_STALL_CNT_EN) counter saturation.
module tb_pipe_skid_reg;

  localparam int DATA_W     = 64;
  localparam int NUM_FREEZE = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        freeze;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int vectors = 0;
  int misses  = 0;

  pipe_skid_reg #(
    .DATA_W     (DATA_W),
    .NUM_FREEZE (NUM_FREEZE),
    .FLUSH_VAL  (64'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .freeze    (freeze)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    freeze    = 2'b00;

    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'h0);
    step();
    step();
    chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
`ifdef PIPE_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    rst = 1'b0;
    step();
    chk("rst_release_in_ready", 64'(in_ready), 64'd1);
    chk("rst_release_out_valid", 64'(out_valid), 64'd0);

    // Streaming 1,2,3
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 64'd1;
    #1;
    chk("stream_latency", 64'(out_valid), 64'd0);
    step();
    chk("stream_v1", 64'(out_valid), 64'd1);
    chk("stream_d1", out_data, 64'd1);
    in_data = 64'd2;
    step();
    chk("stream_d2", out_data, 64'd2);
    in_data = 64'd3;
    step();
    chk("stream_d3", out_data, 64'd3);
    chk("stream_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_drain_hold", out_data, 64'd3);

    // Backpressure: A then B with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hAAAA;
    step();
    chk("bp_full_in_ready", 64'(in_ready), 64'd1);
    in_data = 64'hBBBB;
    step();
    chk("bp_skid_in_ready", 64'(in_ready), 64'd0);
    chk("bp_skid_out_valid", 64'(out_valid), 64'd1);
    chk("bp_skid_data_a", out_data, 64'hAAAA);
    in_valid  = 1'b0;
    in_data   = 64'hDEAD;
    out_ready = 1'b1;
    step();
    chk("bp_out_b", out_data, 64'hBBBB);
    chk("bp_out_b_valid", 64'(out_valid), 64'd1);
    chk("bp_reopen_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("bp_empty_valid", 64'(out_valid), 64'd0);
    chk("bp_empty_hold", out_data, 64'hBBBB);

    // Freeze while FULL with out_ready high
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hF1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    freeze    = 2'b10;
    #1;
    chk("frz_out_valid", 64'(out_valid), 64'd0);
    chk("frz_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_hold_valid", 64'(out_valid), 64'd0);
      chk("frz_hold_data", out_data, 64'hF1);
    end
    freeze = 2'b00;
    #1;
    chk("frz_emerge_valid", 64'(out_valid), 64'd1);
    chk("frz_emerge_data", out_data, 64'hF1);
`ifdef PIPE_STALL_CNT_EN
    chk("frz_stall_cnt", 64'(stall_cnt), 64'd3);
`endif
    step();
    chk("frz_drained", 64'(out_valid), 64'd0);

    // Flush together with freeze while SKID, offering a payload
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h51;
    step();
    in_data = 64'h52;
    step();
    chk("fl_skid_in_ready", 64'(in_ready), 64'd0);
    in_data = 64'hBAD;
    flush   = 1'b1;
    freeze  = 2'b01;
    #1;
    chk("fl_in_ready_gated", 64'(in_ready), 64'd0);
    step();
    flush     = 1'b0;
    freeze    = 2'b00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("fl_empty_valid", 64'(out_valid), 64'd0);
    chk("fl_data_nop", out_data, 64'h0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STALL_CNT_EN
    chk("fl_stall_cnt", 64'(stall_cnt), 64'd4);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_output", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b1;
    in_data  = 64'hD1;
    step();
    in_valid = 1'b0;
    chk("fl_fresh_data", out_data, 64'hD1);
    chk("fl_fresh_valid", 64'(out_valid), 64'd1);
    step();
    chk("fl_fresh_once", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream while SKID
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h71;
    step();
    in_data = 64'h72;
    step();
    in_valid = 1'b0;
    chk("rs_skid_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async_valid", 64'(out_valid), 64'd0);
    chk("rs_async_in_ready", 64'(in_ready), 64'd0);
    chk("rs_async_data", out_data, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rs_release_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("rs_entries_gone", 64'(out_valid), 64'd0);
`ifdef PIPE_STALL_CNT_EN
    chk("rs_stall_cnt", 64'(stall_cnt), 64'd0);

    // Counter saturation
    freeze = 2'b11;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre", 64'(stall_cnt), 64'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    chk("sat_max", 64'(stall_cnt), 64'hFFFF);
    freeze = 2'b00;
    flush  = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("sat_after_flush", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The module SHALL have parameter DATA_W, default 64, giving the payload width (PC plus instruction).
REQ-002 The module SHALL have parameter NUM_FREEZE, default 2, giving the number of independent freeze sources (for example hazard and memory).
REQ-003 The module SHALL have parameter FLUSH_VAL, default 0, giving the out_data value after reset or flush (a NOP bubble).
REQ-004 The module SHALL use clock clk, rising-edge.
REQ-005 The module SHALL use reset rst, asynchronous, active-high.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the upstream payload is valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the block accepts a payload this cycle.
REQ-008 The module SHALL have port in_data, input, DATA_W bits: the upstream payload.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-011 The module SHALL have port out_data, output, DATA_W bits: the registered payload.
REQ-012 The module SHALL have port flush, input, 1 bit: discard all held payloads.
REQ-013 The module SHALL have port freeze, input, NUM_FREEZE bits: freeze requests, where any set bit freezes the stage.
REQ-014 The module SHALL have port stall_cnt, output, 16 bits: the freeze-cycle counter, present only under the configuration macro.

Function
REQ-015 The block SHALL hold a main entry and a skid entry, with states EMPTY (neither valid), FULL (main valid only) and SKID (both valid).
REQ-016 The block SHALL define freeze_any = OR of the freeze bits; in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-017 in_ready SHALL be registered: 1 in EMPTY and FULL, 0 in SKID, and 0 in any cycle where freeze_any or flush is 1.
REQ-018 out_valid SHALL be 1 in FULL and SKID and 0 in EMPTY, and SHALL be forced to 0 in any cycle where freeze_any is 1.
REQ-019 out_data SHALL always equal the main entry; in EMPTY it SHALL hold its last value; it SHALL never be X after reset.
REQ-020 Transitions from EMPTY SHALL be: on in_fire go to FULL and load main with in_data; otherwise stay in EMPTY.
REQ-021 Transitions from FULL SHALL be:
  - in_fire with out_fire: stay in FULL, main <= in_data.
  - in_fire without out_fire: go to SKID, skid <= in_data.
  - out_fire without in_fire: go to EMPTY.
  - neither: hold.
REQ-022 Transitions from SKID SHALL be: on out_fire go to FULL with main <= skid; otherwise hold.
REQ-023 Latency SHALL be 1 cycle from in_fire to out_valid when the block is EMPTY and unfrozen.
REQ-024 A payload SHALL never be dropped or duplicated except by flush.
REQ-025 Flush SHALL take priority over freeze and over both handshakes: the next state SHALL be EMPTY, out_data SHALL become FLUSH_VAL, and a payload offered in the flush cycle SHALL be discarded.
REQ-026 While freeze_any is 1, the block SHALL hold all state and data and SHALL perform no transfers on either side.
REQ-027 A freeze and an out_ready in the same cycle SHALL NOT cause a transfer.

Reset
REQ-028 On rst the block SHALL enter EMPTY with main = skid = FLUSH_VAL, in_ready = 0 and out_valid = 0; stall_cnt SHALL be 0 when present.
REQ-029 in_ready SHALL become 1 on the first clock edge after rst deasserts.
REQ-030 An rst asserted mid-operation SHALL discard both entries immediately.

Configuration
REQ-031 With PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment on each cycle where freeze_any is 1, saturate at 0xFFFF, clear only on rst, and be unaffected by flush.
REQ-032 Without PIPE_STALL_CNT_EN, the stall_cnt port and its counter logic SHALL be absent.

Structure
REQ-033 Package mips_pipe_pkg SHALL hold the state enum (EMPTY, FULL, SKID), the NOP encoding used as the FLUSH_VAL default, and the IF payload width constants.
REQ-034 The skid entry SHALL be a sub-module, pipe_skid_entry: a DATA_W register with load and clear inputs.
REQ-035 IF, ID and EX stage registers SHALL instantiate pipe_skid_reg in place of their current hand-written stage registers.

Verification
REQ-036 The bench SHALL cover streaming: in_valid = 1 and out_ready = 1 every cycle with data 1, 2, 3 -> out_data 1, 2, 3 on consecutive cycles, starting 1 cycle after the first input.
REQ-037 The bench SHALL cover backpressure: out_ready = 0 while A then B are offered -> state SKID, in_ready = 0; then out_ready = 1 -> A, then B, then EMPTY.
REQ-038 The bench SHALL cover freeze: freeze = 2'b10 for 3 cycles while FULL with out_ready = 1 -> out_valid = 0 and data held; the payload emerges on the first unfrozen cycle; stall_cnt = 3.
REQ-039 The bench SHALL cover flush with freeze: flush = 1 and freeze = 2'b01 in SKID with in_valid = 1 -> next cycle EMPTY, out_data = FLUSH_VAL, and the offered payload is never output.
REQ-040 The bench SHALL cover reset mid-stream: rst asserted asynchronously between edges while SKID -> out_valid = 0 immediately, in_ready = 1 on the first edge after release.
REQ-041 The bench SHALL cover counter saturation: freeze held for 70000 cycles -> stall_cnt = 0xFFFF, and stall_cnt stays 0xFFFF after a flush.
